// File: rtl/stream_rr_select_arbiter_pkg.sv
// stream_rr_select_arbiter_pkg: shared select-width helper and arbiter FSM states
package stream_rr_select_arbiter_pkg;
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
    typedef enum logic {ARB, OFFER} arb_state_e;
endpackage

// File: rtl/stream_rr_select_arbiter_if.sv
// stream_rr_select_arbiter_if: ready/valid select-token channel toward the stream multiplexer
interface stream_rr_select_arbiter_if #(parameter int NUM_STREAMS = 4) ();
    import stream_rr_select_arbiter_pkg::*;
    localparam int SEL_W = sel_width(NUM_STREAMS);
    logic             select_valid;
    logic [SEL_W-1:0] select_data;
    logic             select_ready;
    modport master (output select_valid, output select_data, input select_ready);
    modport slave (input select_valid, input select_data, output select_ready);
endinterface

// File: rtl/stream_rr_select_arbiter_pick.sv
// rr_priority_pick: first set bit of eligible at or after start, wrapping modulo N
module rr_priority_pick
    import stream_rr_select_arbiter_pkg::*;
#(
    parameter int N = 4,
    parameter int SEL_W = sel_width(N)
) (
    input  logic [N-1:0]     eligible,
    input  logic [SEL_W-1:0] start,
    output logic             found,
    output logic [SEL_W-1:0] idx
);
    logic [2*N-1:0] dbl;
    assign dbl = {eligible, eligible} >> start;
    always_comb begin
        found = |eligible;
        idx = '0;
        for (int k = N - 1; k >= 0; k--)
            if (dbl[k]) idx = SEL_W'((int'(start) + k) % N);
    end
endmodule

// File: rtl/stream_rr_select_arbiter.sv
// stream_rr_select_arbiter: issues one stream index per packet, round robin with burst allowance
module stream_rr_select_arbiter
    import stream_rr_select_arbiter_pkg::*;
#(
    parameter int NUM_STREAMS = 4,
    parameter int BURST = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_STREAMS-1:0]          req,
    input  logic [NUM_STREAMS-1:0]          enable_mask,
    stream_rr_select_arbiter_if.master      sel,
    output logic [31:0]                     grant_count
);
    localparam int SEL_W = sel_width(NUM_STREAMS);
    localparam int BW = $clog2(BURST + 1);
    localparam logic [BW-1:0] BURST_C = BW'(BURST);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_STREAMS - 1);

    arb_state_e       state_q, state_d;
    logic             valid_q, valid_d;
    logic [SEL_W-1:0] data_q, data_d, rr_ptr_q, rr_ptr_d, last_sel_q, last_sel_d;
    logic [BW-1:0]    burst_cnt_q, burst_cnt_d;
    logic [31:0]      grant_count_q, grant_count_d;
    logic [NUM_STREAMS-1:0] eligible;
    logic             found, cont;
    logic [SEL_W-1:0] pick_idx;

    assign eligible = req & enable_mask;
    assign cont = (burst_cnt_q < BURST_C) && eligible[last_sel_q] && (burst_cnt_q != '0);

    rr_priority_pick #(.N(NUM_STREAMS), .SEL_W(SEL_W)) u_pick (
        .eligible(eligible),
        .start(rr_ptr_q),
        .found(found),
        .idx(pick_idx)
    );

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        data_d = data_q;
        rr_ptr_d = rr_ptr_q;
        last_sel_d = last_sel_q;
        burst_cnt_d = burst_cnt_q;
        grant_count_d = grant_count_q;
        if (state_q == ARB) begin
            if (found) begin
                valid_d = 1'b1;
                data_d = cont ? last_sel_q : pick_idx;
                burst_cnt_d = cont ? burst_cnt_q : '0;
                state_d = OFFER;
            end
        end else if (sel.select_ready) begin
            // token stays frozen until accepted; the next decision waits a cycle for fresh req
            valid_d = 1'b0;
            last_sel_d = data_q;
            burst_cnt_d = (burst_cnt_q == BURST_C) ? BURST_C : burst_cnt_q + 1'b1;
            rr_ptr_d = (data_q == LAST_IDX) ? '0 : data_q + 1'b1;
            grant_count_d = grant_count_q + 32'd1;
            state_d = ARB;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB;
            valid_q <= 1'b0;
            data_q <= '0;
            rr_ptr_q <= '0;
            last_sel_q <= '0;
            burst_cnt_q <= '0;
            grant_count_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            data_q <= data_d;
            rr_ptr_q <= rr_ptr_d;
            last_sel_q <= last_sel_d;
            burst_cnt_q <= burst_cnt_d;
            grant_count_q <= grant_count_d;
        end
    end

    assign sel.select_valid = valid_q;
    assign sel.select_data = data_q;
    assign grant_count = grant_count_q;
endmodule

// File: tb/tb_stream_rr_select_arbiter.sv
// tb_stream_rr_select_arbiter: directed checks on three arbiter configurations sharing one clock
module tb_stream_rr_select_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b0;
    logic [1:0] which = 2'd0;
    logic [3:0] req = '0;
    logic [3:0] mask = 4'hf;
    logic [31:0] gc_a, gc_b, gc_c;
    logic cur_valid;
    logic [1:0] cur_data;
    logic [31:0] cur_gc;
    int n_pass = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    stream_rr_select_arbiter_if #(.NUM_STREAMS(4)) a_if ();
    stream_rr_select_arbiter_if #(.NUM_STREAMS(4)) b_if ();
    stream_rr_select_arbiter_if #(.NUM_STREAMS(3)) c_if ();

    assign a_if.select_ready = rdy && (which == 2'd0);
    assign b_if.select_ready = rdy && (which == 2'd1);
    assign c_if.select_ready = rdy && (which == 2'd2);
    assign cur_valid = (which == 2'd0) ? a_if.select_valid : (which == 2'd1) ? b_if.select_valid : c_if.select_valid;
    assign cur_data = (which == 2'd0) ? a_if.select_data : (which == 2'd1) ? b_if.select_data : c_if.select_data;
    assign cur_gc = (which == 2'd0) ? gc_a : (which == 2'd1) ? gc_b : gc_c;

    stream_rr_select_arbiter #(.NUM_STREAMS(4), .BURST(1)) dut_a (
        .clk(clk), .rst(rst), .req(req), .enable_mask(mask), .sel(a_if), .grant_count(gc_a));
    stream_rr_select_arbiter #(.NUM_STREAMS(4), .BURST(3)) dut_b (
        .clk(clk), .rst(rst), .req(req), .enable_mask(mask), .sel(b_if), .grant_count(gc_b));
    stream_rr_select_arbiter #(.NUM_STREAMS(3), .BURST(1)) dut_c (
        .clk(clk), .rst(rst), .req(req[2:0]), .enable_mask(mask[2:0]), .sel(c_if), .grant_count(gc_c));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic get(input logic [31:0] exp, input string tag);
        int n = 0;
        while (!cur_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " valid"}, {31'd0, cur_valid}, 32'd1);
        chk({tag, " data"}, {30'd0, cur_data}, exp);
        rdy = 1'b1;
        @(negedge clk);
        rdy = 1'b0;
        chk({tag, " bubble"}, {31'd0, cur_valid}, 32'd0);
    endtask

    task automatic restart(input logic [1:0] w, input logic [3:0] r, input logic [3:0] m);
        rst = 1'b1;
        rdy = 1'b0;
        which = w;
        @(negedge clk);
        rst = 1'b0;
        req = r;
        mask = m;
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("reset valid", {31'd0, a_if.select_valid}, 32'd0);
        chk("reset data", {30'd0, a_if.select_data}, 32'd0);
        chk("reset gc", gc_a, 32'd0);
        rst = 1'b0;
        req = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            get(2, "single");
            @(negedge clk);
            chk("single reoffer", {31'd0, cur_valid}, 32'd1);
        end

        restart(2'd0, 4'b1111, 4'b1111);
        get(0, "rr0");
        get(1, "rr1");
        get(2, "rr2");
        get(3, "rr3");
        get(0, "rr4");
        chk("rr gc", cur_gc, 32'd5);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            req = i[0] ? 4'b0000 : 4'b1101;
            mask = i[1] ? 4'b0001 : 4'b1110;
            @(negedge clk);
            chk("hold valid", {31'd0, cur_valid}, 32'd1);
            chk("hold data", {30'd0, cur_data}, 32'd1);
        end
        chk("hold gc", cur_gc, 32'd5);
        req = 4'b1111;
        mask = 4'b1111;
        get(1, "hold accept");
        chk("hold gc after", cur_gc, 32'd6);

        restart(2'd1, 4'b0011, 4'b1111);
        get(0, "burst0a");
        get(0, "burst0b");
        get(0, "burst0c");
        get(1, "burst1a");
        get(1, "burst1b");
        get(1, "burst1c");
        get(0, "burst0d");

        restart(2'd1, 4'b0011, 4'b1111);
        get(0, "drop first");
        req = 4'b0010;
        get(1, "drop next");

        restart(2'd2, 4'b0111, 4'b0101);
        get(0, "mask0a");
        get(2, "mask2a");
        get(0, "mask0b");
        get(2, "mask2b");
        chk("mask gc", cur_gc, 32'd4);

        restart(2'd0, 4'b1111, 4'b1111);
        get(0, "pre reset");
        @(negedge clk);
        chk("offer before reset", {31'd0, cur_valid}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid reset valid", {31'd0, cur_valid}, 32'd0);
        chk("mid reset gc", cur_gc, 32'd0);
        rst = 1'b0;
        req = 4'b1000;
        get(3, "post reset");
        chk("post reset gc", cur_gc, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
